// File: rtl/maxpool_engine_if.sv
// Bundles the pooling engine's controller handshake and RAM read/write ports; the
// mode signal exists only when POOL_AVG_EN is defined. master = engine side.
interface maxpool_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              start;
`ifdef POOL_AVG_EN
  logic              mode;
`endif
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

`ifdef POOL_AVG_EN
  modport master (
    input  start, mode, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
  modport slave (
    output start, mode, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
`else
  modport master (
    input  start, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
  modport slave (
    output start, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
`endif
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 pooling over a RAM-resident feature map; POOL_AVG_EN adds average mode.
// Latency: 6 cycles per output, done 1+6*OH*OW edges after start.
// No backpressure: RAM read data is assumed valid exactly one cycle after rd_en.
module maxpool_engine #(
  parameter int FMAP_W = 6,
  parameter int FMAP_H = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  maxpool_engine_if.master  bus
);

  localparam int OW = FMAP_W / 2;
  localparam int OH = FMAP_H / 2;
`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_W + 2;
`else
  localparam int ACC_W = DATA_W;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t                   state;
  logic [1:0]               k;
  logic [ADDR_W-1:0]        orow;
  logic [ADDR_W-1:0]        ocol;
  logic signed [ACC_W-1:0]  acc;
`ifdef POOL_AVG_EN
  logic                     mode_q;
`endif

  logic signed [DATA_W-1:0] px;
  logic signed [ACC_W-1:0]  px_ext;
  logic signed [ACC_W-1:0]  fold;
  logic [DATA_W-1:0]        wr_val;
  logic                     last_col;
  logic                     last_win;
  logic [ADDR_W-1:0]        nxt_orow;
  logic [ADDR_W-1:0]        nxt_ocol;

  // Pixel address of read k (TL, TR, BL, BR) in window (r, c).
  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] r,
                                                 input logic [ADDR_W-1:0] c,
                                                 input logic [1:0]        kk);
    int a;
    a = (2 * int'(r) + int'(kk[1])) * FMAP_W + 2 * int'(c) + int'(kk[0]);
    return ADDR_W'(a);
  endfunction

  assign px     = $signed(bus.rd_data);
  assign px_ext = ACC_W'(px);

  always_comb begin
    fold = (px_ext > acc) ? px_ext : acc;
`ifdef POOL_AVG_EN
    if (mode_q) fold = acc + px_ext;
`endif
  end

  always_comb begin
    wr_val = DATA_W'(fold);
`ifdef POOL_AVG_EN
    if (mode_q) wr_val = DATA_W'(fold >>> 2);
`endif
  end

  assign last_col = (ocol == ADDR_W'(OW - 1));
  assign last_win = last_col && (orow == ADDR_W'(OH - 1));
  assign nxt_ocol = last_col ? '0 : ocol + ADDR_W'(1);
  assign nxt_orow = last_col ? orow + ADDR_W'(1) : orow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      k           <= '0;
      orow        <= '0;
      ocol        <= '0;
      acc         <= '0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state       <= S_RD;
            k           <= '0;
            orow        <= '0;
            ocol        <= '0;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= win_addr('0, '0, 2'd0);
            bus.busy    <= 1'b1;
            bus.done    <= 1'b0;
`ifdef POOL_AVG_EN
            mode_q      <= bus.mode;
`endif
          end
        end
        S_RD: begin
          // rd_data in this cycle belongs to read k-1
          if (k == 2'd1)      acc <= px_ext;
          else if (k != 2'd0) acc <= fold;
          if (k == 2'd3) begin
            state     <= S_CAP;
            bus.rd_en <= 1'b0;
          end else begin
            k           <= k + 2'd1;
            bus.rd_addr <= win_addr(orow, ocol, k + 2'd1);
          end
        end
        S_CAP: begin
          // BR pixel folds straight into the registered write value
          state       <= S_WR;
          bus.wr_en   <= 1'b1;
          bus.wr_data <= wr_val;
          bus.wr_addr <= ADDR_W'(int'(orow) * OW + int'(ocol));
        end
        S_WR: begin
          bus.wr_en <= 1'b0;
          if (last_win) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state       <= S_RD;
            k           <= '0;
            orow        <= nxt_orow;
            ocol        <= nxt_ocol;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= win_addr(nxt_orow, nxt_ocol, 2'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
